// File: rtl/tick_scheduler_if.sv
// Configuration, strobe and pulse bundle for tick_scheduler.
// The IRQ signals exist only when TICK_SCHED_IRQ_EN is defined.
interface tick_scheduler_if #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                CFG_WE;
  logic [CH_W-1:0]     CFG_CH;
  logic [PERIOD_W-1:0] CFG_PERIOD;
  logic                CFG_ONESHOT;
  logic [NUM_CH-1:0]   START;
  logic [NUM_CH-1:0]   STOP;
  logic                TICK_OUT;
  logic [NUM_CH-1:0]   PULSE_OUT;
  logic [NUM_CH-1:0]   BUSY;
`ifdef TICK_SCHED_IRQ_EN
  logic [NUM_CH-1:0]   IRQ_ACK;
  logic [NUM_CH-1:0]   IRQ_PEND;
  logic                IRQ;
`endif

  modport master (
    output CFG_WE, CFG_CH, CFG_PERIOD, CFG_ONESHOT,
    output START, STOP,
    input  TICK_OUT, PULSE_OUT, BUSY
`ifdef TICK_SCHED_IRQ_EN
    , output IRQ_ACK
    , input  IRQ_PEND, IRQ
`endif
  );

  modport slave (
    input  CFG_WE, CFG_CH, CFG_PERIOD, CFG_ONESHOT,
    input  START, STOP,
    output TICK_OUT, PULSE_OUT, BUSY
`ifdef TICK_SCHED_IRQ_EN
    , input  IRQ_ACK
    , output IRQ_PEND, IRQ
`endif
  );
endinterface

// File: rtl/tick_scheduler.sv
// Shared prescaled tick driving NUM_CH programmable pulse channels.
// Optional interrupt pending/ack logic under TICK_SCHED_IRQ_EN.
module tick_scheduler #(
  parameter int FREQ_IN   = 1000,
  parameter int FREQ_TICK = 100,
  parameter int NUM_CH    = 4,
  parameter int PERIOD_W  = 8
) (
  input  logic           CLK_IN,
  input  logic           RST_N,
  tick_scheduler_if.slave bus
);
  localparam int DIVIDER = FREQ_IN / FREQ_TICK;
  localparam int PS_W    = $clog2(DIVIDER);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_int;
  logic            tick_q;

  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0][PERIOD_W-1:0] per_q, per_d;
  logic [NUM_CH-1:0][PERIOD_W-1:0] cnt_q, cnt_d;

  logic              cfg_ok;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] kill;
  logic [NUM_CH-1:0] term;

  assign tick_int = (ps_q == PS_W'(DIVIDER - 1));

  always_comb begin
    ps_d = tick_int ? '0 : ps_q + PS_W'(1);
  end

  assign cfg_ok = bus.CFG_WE && (int'(bus.CFG_CH) < NUM_CH);

  // Terminal uses >= so a period shrunk below the count fires next tick.
  always_comb begin
    wr   = '0;
    kill = '0;
    term = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i]   = cfg_ok && (bus.CFG_CH == CH_W'(i));
      kill[i] = wr[i] && (bus.CFG_PERIOD == '0);
      term[i] = tick_int &&
                (cnt_q[i] >= per_q[i] - PERIOD_W'(1));
    end
  end

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    mode_d = mode_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr[i]) begin
        per_d[i]  = bus.CFG_PERIOD;
        mode_d[i] = bus.CFG_ONESHOT;
      end
      if (!run_q[i]) begin
        if (bus.START[i] && !bus.STOP[i] &&
            per_q[i] != '0) begin
          run_d[i] = 1'b1;
          cnt_d[i] = '0;
        end
      end else begin
        if (bus.STOP[i]) begin
          run_d[i] = 1'b0;
          cnt_d[i] = '0;
        end else if (bus.START[i]) begin
          cnt_d[i] = '0;
        end else if (term[i]) begin
          cnt_d[i] = '0;
          if (mode_q[i]) run_d[i] = 1'b0;
        end else if (tick_int) begin
          cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
        end
      end
      if (kill[i]) begin
        run_d[i] = 1'b0;
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_d[i] = run_q[i] && term[i] &&
                   !bus.STOP[i] && !bus.START[i] &&
                   !kill[i];
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      ps_q    <= '0;
      tick_q  <= 1'b0;
      run_q   <= '0;
      mode_q  <= '0;
      pulse_q <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ps_q    <= ps_d;
      tick_q  <= tick_int;
      run_q   <= run_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.TICK_OUT  = tick_q;
  assign bus.PULSE_OUT = pulse_q;
  assign bus.BUSY      = run_q;

`ifdef TICK_SCHED_IRQ_EN
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic              irq_q, irq_d;

  // A new pulse wins over an ack arriving in the same cycle.
  always_comb begin
    pend_d = (pend_q & ~bus.IRQ_ACK) | pulse_d;
    irq_d  = |pend_d;
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.IRQ_PEND = pend_q;
  assign bus.IRQ      = irq_q;
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed vector bench for tick_scheduler (DIVIDER=10, 4 channels).
// Vector e = rising edge count since reset release.
module tb_tick_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tick_scheduler_if #(.NUM_CH(4), .PERIOD_W(8)) bus ();

  tick_scheduler #(
    .FREQ_IN(1000), .FREQ_TICK(100),
    .NUM_CH(4), .PERIOD_W(8)
  ) dut (
    .CLK_IN(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         e;
    logic       we;
    logic [1:0] ch;
    logic [7:0] per;
    logic       os;
    logic [3:0] start;
    logic [3:0] stop;
    logic [3:0] ack;
    logic       tick;
    logic [3:0] pulse;
    logic [3:0] busy;
    logic [3:0] pend;
    logic       irq;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int npulse[4];
  logic [3:0] prev_p;

  task automatic v(input int e, input logic we,
                   input logic [1:0] ch, input logic [7:0] per,
                   input logic os, input logic [3:0] start,
                   input logic [3:0] stop, input logic [3:0] ack,
                   input logic tick, input logic [3:0] pulse,
                   input logic [3:0] busy, input logic [3:0] pend,
                   input logic irq);
    vec_t r;
    r.e = e; r.we = we; r.ch = ch; r.per = per; r.os = os;
    r.start = start; r.stop = stop; r.ack = ack;
    r.tick = tick; r.pulse = pulse; r.busy = busy;
    r.pend = pend; r.irq = irq;
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.CFG_WE = 1'b0;
    bus.CFG_CH = '0;
    bus.CFG_PERIOD = '0;
    bus.CFG_ONESHOT = 1'b0;
    bus.START = '0;
    bus.STOP = '0;
`ifdef TICK_SCHED_IRQ_EN
    bus.IRQ_ACK = '0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (bus.PULSE_OUT[i]) npulse[i]++;
    chk($sformatf("pulse_twice@%0d", cyc),
        32'(bus.PULSE_OUT & prev_p), 32'd0);
    prev_p = bus.PULSE_OUT;
  endtask

  initial begin
    idle_in();
    prev_p = '0;
    for (int i = 0; i < 4; i++) npulse[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(bus.TICK_OUT), 32'd0);
    chk("rst_pulse", 32'(bus.PULSE_OUT), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    rst_n = 1'b1;

    //  e   we ch per os st   sp   ack  tk pulse busy pend irq
    v(  5, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0);
    v( 10, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    v( 11, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0);
    v( 20, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    v( 30, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    v( 41, 1, 0, 3, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0);
    v( 42, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 0);
    v( 43, 1, 1, 2, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 0);
    v( 44, 0, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h3, 4'h0, 0);
    v( 45, 1, 2, 4, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h3, 4'h0, 0);
    v( 46, 0, 0, 0, 0, 4'h4, 4'h0, 4'h0, 0, 4'h0, 4'h7, 4'h0, 0);
    v( 50, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h7, 4'h0, 0);
    v( 60, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h2, 4'h5, 4'h2, 1);
    v( 61, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h5, 4'h2, 1);
    v( 70, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h5, 4'h3, 1);
    v( 71, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h5, 4'h3, 1);
    v( 80, 0, 0, 0, 0, 4'h0, 4'h4, 4'h0, 1, 4'h0, 4'h1, 4'h3, 1);
    v( 81, 0, 0, 0, 0, 4'h4, 4'h0, 4'h0, 0, 4'h0, 4'h5, 4'h3, 1);
    v( 82, 1, 3, 5, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h5, 4'h3, 1);
    v( 83, 0, 0, 0, 0, 4'h8, 4'h0, 4'h0, 0, 4'h0, 4'hD, 4'h3, 1);
    v(100, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 1, 4'h1, 4'hD, 4'h3, 1);
    v(105, 0, 0, 0, 0, 4'h0, 4'h0, 4'h3, 0, 4'h0, 4'hD, 4'h0, 0);
    v(110, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'hD, 4'h0, 0);
    v(115, 1, 3, 2, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'hD, 4'h0, 0);
    v(120, 0, 0, 0, 0, 4'h4, 4'h0, 4'h0, 1, 4'h8, 4'hD, 4'h8, 1);
    v(125, 1, 3, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h5, 4'h8, 1);
    v(130, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h5, 4'h9, 1);
    v(160, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h5, 4'h5, 4'hD, 1);
    v(161, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h5, 4'hD, 1);
    v(165, 0, 0, 0, 0, 4'h0, 4'h4, 4'h0, 0, 4'h0, 4'h1, 4'hD, 1);
    v(190, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h1, 4'hD, 1);
    v(200, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h1, 4'hD, 1);

    foreach (vq[k]) begin
      while (cyc < vq[k].e - 1) step();
      bus.CFG_WE = vq[k].we;
      bus.CFG_CH = vq[k].ch;
      bus.CFG_PERIOD = vq[k].per;
      bus.CFG_ONESHOT = vq[k].os;
      bus.START = vq[k].start;
      bus.STOP = vq[k].stop;
`ifdef TICK_SCHED_IRQ_EN
      bus.IRQ_ACK = vq[k].ack;
`endif
      step();
      idle_in();
      chk($sformatf("tick@%0d", cyc),
          32'(bus.TICK_OUT), 32'(vq[k].tick));
      chk($sformatf("pulse@%0d", cyc),
          32'(bus.PULSE_OUT), 32'(vq[k].pulse));
      chk($sformatf("busy@%0d", cyc),
          32'(bus.BUSY), 32'(vq[k].busy));
`ifdef TICK_SCHED_IRQ_EN
      chk($sformatf("pend@%0d", cyc),
          32'(bus.IRQ_PEND), 32'(vq[k].pend));
      chk($sformatf("irq@%0d", cyc),
          32'(bus.IRQ), 32'(vq[k].irq));
`endif
    end

    // ch0 every 3rd tick; one-shot ch1 once; ch2 and ch3 once each
    chk("npulse0", 32'(npulse[0]), 32'd5);
    chk("npulse1", 32'(npulse[1]), 32'd1);
    chk("npulse2", 32'(npulse[2]), 32'd1);
    chk("npulse3", 32'(npulse[3]), 32'd1);

    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", 32'(bus.TICK_OUT), 32'd0);
    chk("async_rst_pulse", 32'(bus.PULSE_OUT), 32'd0);
    chk("async_rst_busy", 32'(bus.BUSY), 32'd0);
`ifdef TICK_SCHED_IRQ_EN
    chk("async_rst_pend", 32'(bus.IRQ_PEND), 32'd0);
    chk("async_rst_irq", 32'(bus.IRQ), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
